// File: rtl/fpu_seq_if.sv
// Operand/result handshake bundle for fpu_seq: valid/ready on the request and response sides.
interface fpu_seq_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int W = EXP_W + MAN_W + 1;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] o;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, o, flags
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, o, flags
    );
endinterface

// File: rtl/fpu_seq.sv
// Multi-cycle FPU (ADD/SUB/MUL/DIV, restoring divider) with valid/ready handshake and IEEE flags.
// Define FPU_SEQ_RNE_EN for round-to-nearest-even in NORM; the default build truncates.
module fpu_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input logic      clk,
    input logic      rst_n,
    fpu_seq_if.slave bus
);
    localparam int W   = EXP_W + MAN_W + 1;
    localparam int M   = MAN_W + 1;
    localparam int AW  = M + 3;
    localparam int WM  = 2 * M;
    localparam int EW  = EXP_W + 2;
    localparam int LZW = $clog2(WM);
    localparam int NIT = MAN_W + 3;
    localparam int CW  = $clog2(NIT);
    localparam int SHW = $clog2(AW);

    localparam logic signed [EW-1:0] Bias   = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] ExpMax = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]         QNan   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
    localparam logic [1:0] OpAdd = 2'b00, OpSub = 2'b01, OpDiv = 2'b10, OpMul = 2'b11;

    typedef enum logic [2:0] {StIdle, StUnpack, StExec, StNorm, StDone} state_e;

    function automatic logic [W-1:0] inf_of(input logic s);
        return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    endfunction

    state_e               state_q;
    logic [W-1:0]         a_q, b_q, o_q;
    logic [1:0]           op_q;
    logic [3:0]           flags_q;
    logic                 in_ready_q, out_valid_q, special_q, sign_q, sticky_q;
    logic signed [EW-1:0] exp_q;
    logic [WM-1:0]        mant_q;
    logic [M:0]           rem_q;
    logic [NIT-1:0]       quo_q;
    logic [CW-1:0]        cnt_q;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.o         = o_q;
    assign bus.flags     = flags_q;

    // Field split; exponent 0 covers subnormals, which are flushed to signed zero.
    logic                 sa, sb, za, zb, ia, ib, na, nb;
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic [M-1:0]         ma, mb;
    logic signed [EW-1:0] ea_s, eb_s;

    assign sa   = a_q[W-1];
    assign sb   = b_q[W-1] ^ (op_q == OpSub);
    assign ea   = a_q[W-2 -: EXP_W];
    assign eb   = b_q[W-2 -: EXP_W];
    assign fa   = a_q[MAN_W-1:0];
    assign fb   = b_q[MAN_W-1:0];
    assign za   = (ea == '0);
    assign zb   = (eb == '0);
    assign ia   = (&ea) && (fa == '0);
    assign ib   = (&eb) && (fb == '0);
    assign na   = (&ea) && (fa != '0);
    assign nb   = (&eb) && (fb != '0);
    assign ma   = za ? '0 : {1'b1, fa};
    assign mb   = zb ? '0 : {1'b1, fb};
    assign ea_s = $signed({2'b00, ea});
    assign eb_s = $signed({2'b00, eb});

    logic         spec;
    logic [W-1:0] spec_o;
    logic [3:0]   spec_f;

    always_comb begin
        spec   = 1'b1;
        spec_o = '0;
        spec_f = '0;
        if (na || nb) begin
            spec_o    = QNan;
            spec_f[3] = (na && !fa[MAN_W-1]) || (nb && !fb[MAN_W-1]);
        end else begin
            unique case (op_q)
                OpAdd, OpSub: begin
                    if (ia && ib && (sa != sb)) begin
                        spec_o    = QNan;
                        spec_f[3] = 1'b1;
                    end else if (ia)       spec_o = inf_of(sa);
                    else if (ib)           spec_o = inf_of(sb);
                    else if (za && zb)     spec_o = '0;
                    else if (za)           spec_o = {sb, b_q[W-2:0]};
                    else if (zb)           spec_o = a_q;
                    else                   spec   = 1'b0;
                end
                OpMul: begin
                    if ((za && ib) || (ia && zb)) begin
                        spec_o    = QNan;
                        spec_f[3] = 1'b1;
                    end else if (ia || ib) spec_o = inf_of(sa ^ sb);
                    else if (za || zb)     spec_o = {sa ^ sb, {(W - 1){1'b0}}};
                    else                   spec   = 1'b0;
                end
                default: begin
                    if ((za && zb) || (ia && ib)) begin
                        spec_o    = QNan;
                        spec_f[3] = 1'b1;
                    end else if (ia) spec_o = inf_of(sa ^ sb);
                    else if (zb) begin
                        spec_o    = inf_of(sa ^ sb);
                        spec_f[2] = 1'b1;
                    end else if (ib || za) spec_o = {sa ^ sb, {(W - 1){1'b0}}};
                    else                   spec   = 1'b0;
                end
            endcase
        end
    end

    // ADD/SUB: larger magnitude kept, smaller shifted right with lost bits folded into bit 0.
    logic             a_big;
    logic [EXP_W-1:0] ediff;
    logic [SHW-1:0]   sh;
    logic [AW-1:0]    big_x, sml_x, sml_sh;
    logic [AW:0]      sum;
    logic [WM-1:0]    prod;

    always_comb begin
        a_big     = {ea, ma} >= {eb, mb};
        ediff     = a_big ? ea - eb : eb - ea;
        sh        = (32'(ediff) > AW - 1) ? SHW'(AW - 1) : SHW'(ediff);
        big_x     = {a_big ? ma : mb, 3'b000};
        sml_x     = {a_big ? mb : ma, 3'b000};
        sml_sh    = sml_x >> sh;
        sml_sh[0] = sml_sh[0] | (|(sml_x & ~({AW{1'b1}} << sh)));
        sum       = (sa == sb) ? {1'b0, big_x} + {1'b0, sml_sh}
                               : {1'b0, big_x} - {1'b0, sml_sh};
    end

    assign prod = {{M{1'b0}}, ma} * {{M{1'b0}}, mb};

    logic           qbit;
    logic [M:0]     rem_sub;
    logic [NIT-1:0] quo_nx;

    assign qbit    = rem_q >= {1'b0, mb};
    assign rem_sub = qbit ? rem_q - {1'b0, mb} : rem_q;
    assign quo_nx  = {quo_q[NIT-2:0], qbit};

    // mant_q carries its binary point below bit WM-2; bit WM-1 is the carry-out.
    logic [LZW-1:0]       lz;
    logic [WM-1:0]        nmant;
    logic signed [EW-1:0] nexp, rexp;
    logic                 nsticky;
    logic [MAN_W-1:0]     frac, rfrac;
    logic [W-1:0]         res;
    logic [3:0]           res_f;
`ifdef FPU_SEQ_RNE_EN
    logic                 rnd_inc;
    logic [M:0]           rmant;
    logic                 unused_norm;
    assign unused_norm = ^nmant[WM-1:WM-2];
`else
    logic                 unused_norm;
    assign unused_norm = ^{nmant[WM-1:WM-2], nmant[M-2:0], nsticky};
`endif

    always_comb begin
        lz = LZW'(WM - 1);
        for (int i = 0; i <= WM - 2; i++) begin
            if (mant_q[i]) lz = LZW'(WM - 2 - i);
        end
        if (mant_q[WM-1]) begin
            nmant   = mant_q >> 1;
            nexp    = exp_q + EW'(1);
            nsticky = sticky_q | mant_q[0];
        end else begin
            nmant   = mant_q << lz;
            nexp    = exp_q - $signed({{(EW - LZW){1'b0}}, lz});
            nsticky = sticky_q;
        end
        frac = nmant[WM-3 -: MAN_W];
`ifdef FPU_SEQ_RNE_EN
        rnd_inc = nmant[M-2] & ((|nmant[M-3:0]) | nsticky | frac[0]);
        rmant   = {2'b01, frac} + {{M{1'b0}}, rnd_inc};
        rfrac   = rmant[MAN_W-1:0];
        rexp    = rmant[M] ? nexp + EW'(1) : nexp;
`else
        rfrac = frac;
        rexp  = nexp;
`endif
        res_f = '0;
        if (mant_q == '0) begin
            res = '0;
        end else if (rexp >= ExpMax) begin
            res      = inf_of(sign_q);
            res_f[1] = 1'b1;
        end else if (rexp[EW-1] || (rexp == '0)) begin
            res      = {sign_q, {(W - 1){1'b0}}};
            res_f[0] = 1'b1;
        end else begin
            res = {sign_q, rexp[EXP_W-1:0], rfrac};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            o_q         <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            special_q   <= 1'b0;
            sign_q      <= 1'b0;
            sticky_q    <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        op_q       <= bus.opcode;
                        flags_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StUnpack;
                    end
                end
                StUnpack: begin
                    special_q <= spec;
                    sticky_q  <= 1'b0;
                    cnt_q     <= '0;
                    quo_q     <= '0;
                    rem_q     <= {1'b0, ma};
                    if (spec) begin
                        // Specials skip EXEC; NORM leaves this result untouched.
                        o_q     <= spec_o;
                        flags_q <= spec_f;
                        state_q <= StNorm;
                    end else begin
                        unique case (op_q)
                            OpAdd, OpSub: begin
                                sign_q <= a_big ? sa : sb;
                                exp_q  <= a_big ? ea_s : eb_s;
                            end
                            OpMul: begin
                                sign_q <= sa ^ sb;
                                exp_q  <= ea_s + eb_s - Bias;
                            end
                            default: begin
                                sign_q <= sa ^ sb;
                                exp_q  <= ea_s - eb_s + Bias;
                            end
                        endcase
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (op_q == OpDiv) begin
                        rem_q <= {rem_sub[M-1:0], 1'b0};
                        quo_q <= quo_nx;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(NIT - 1)) begin
                            mant_q   <= {1'b0, quo_nx, {(WM - 1 - NIT){1'b0}}};
                            sticky_q <= (rem_sub != '0);
                            state_q  <= StNorm;
                        end
                    end else begin
                        mant_q  <= (op_q == OpMul) ? prod : {sum, {(WM - AW - 1){1'b0}}};
                        state_q <= StNorm;
                    end
                end
                StNorm: begin
                    if (!special_q) begin
                        o_q     <= res;
                        flags_q <= res_f;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_seq.sv
// Directed vector bench for fpu_seq (binary32), plus back-pressure and mid-DIV reset sequences.
module tb_fpu_seq;
    localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_DIV = 2'b10, OP_MUL = 2'b11;
`ifdef FPU_SEQ_RNE_EN
    localparam logic [31:0] DIV_THIRD = 32'h3EAAAAAB;
    localparam logic [31:0] SUB_TINY  = 32'h3F800000;
`else
    localparam logic [31:0] DIV_THIRD = 32'h3EAAAAAA;
    localparam logic [31:0] SUB_TINY  = 32'h3F7FFFFF;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fpu_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();
    fpu_seq #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] o;
        logic [3:0]  f;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    function automatic void add_vec(input logic [31:0] a, input logic [31:0] b,
                                    input logic [1:0] op, input logic [31:0] o,
                                    input logic [3:0] f, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.o = o; v.f = f; v.lat = lat;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          output logic [31:0] o, output logic [3:0] f, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready before issue", 32'(bus.in_ready), 32'd1);
        check("no stale out_valid", 32'(bus.out_valid), 32'd0);
        bus.a        = a;
        bus.b        = b;
        bus.opcode   = op;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        o = bus.o;
        f = bus.flags;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    logic [31:0] got_o;
    logic [3:0]  got_f;
    int          got_lat;

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.opcode    = '0;
        rst_n         = 1'b0;

        add_vec(32'h3FC00000, 32'h40100000, OP_ADD, 32'h40700000, 4'b0000, 3);
        add_vec(32'h40400000, 32'hC0000000, OP_MUL, 32'hC0C00000, 4'b0000, 3);
        add_vec(32'h7F7FFFFF, 32'h40000000, OP_MUL, 32'h7F800000, 4'b0010, 3);
        add_vec(32'h3F800000, 32'h40400000, OP_DIV, DIV_THIRD,    4'b0000, 28);
        add_vec(32'h3F800000, 32'h00000000, OP_DIV, 32'h7F800000, 4'b0100, 2);
        add_vec(32'h7F800000, 32'h7F800000, OP_SUB, 32'h7FC00000, 4'b1000, 2);
        add_vec(32'h3F800000, 32'h3F800000, OP_SUB, 32'h00000000, 4'b0000, 3);
        add_vec(32'h40400000, 32'h3F800000, OP_SUB, 32'h40000000, 4'b0000, 3);
        add_vec(32'h3F800000, 32'h3F800000, OP_ADD, 32'h40000000, 4'b0000, 3);
        add_vec(32'h7F800001, 32'h3F800000, OP_ADD, 32'h7FC00000, 4'b1000, 2);
        add_vec(32'h7FC00000, 32'h3F800000, OP_MUL, 32'h7FC00000, 4'b0000, 2);
        add_vec(32'h00000000, 32'h7F800000, OP_MUL, 32'h7FC00000, 4'b1000, 2);
        add_vec(32'h00800000, 32'h00800000, OP_MUL, 32'h00000000, 4'b0001, 3);
        add_vec(32'h00000001, 32'h3F800000, OP_ADD, 32'h3F800000, 4'b0000, 2);
        add_vec(32'h00000000, 32'h00000000, OP_DIV, 32'h7FC00000, 4'b1000, 2);
        add_vec(32'h7F800000, 32'h7F800000, OP_DIV, 32'h7FC00000, 4'b1000, 2);
        add_vec(32'hC0C00000, 32'h40000000, OP_DIV, 32'hC0400000, 4'b0000, 28);
        add_vec(32'hFF800000, 32'h3F800000, OP_ADD, 32'hFF800000, 4'b0000, 2);
        add_vec(32'h3F800000, 32'h33800000, OP_SUB, 32'h3F7FFFFF, 4'b0000, 3);
        add_vec(32'h3F800000, 32'h0C800000, OP_SUB, SUB_TINY,     4'b0000, 3);
        add_vec(32'h4B800000, 32'h3F800000, OP_ADD, 32'h4B800000, 4'b0000, 3);

        repeat (3) @(negedge clk);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset o", bus.o, 32'h0);
        check("reset flags", 32'(bus.flags), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, got_o, got_f, got_lat);
            check($sformatf("vec%0d o", i), got_o, vecs[i].o);
            check($sformatf("vec%0d flags", i), 32'(got_f), 32'(vecs[i].f));
            check($sformatf("vec%0d latency", i), 32'(got_lat), 32'(vecs[i].lat));
        end

        // Back-pressure: result held while out_ready is low; a second request is ignored.
        @(negedge clk);
        bus.a        = 32'h3FC00000;
        bus.b        = 32'h40100000;
        bus.opcode   = OP_ADD;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.a  = 32'h3F800000;
        bus.b  = 32'h3F800000;
        got_lat = 0;
        while (!bus.out_valid && got_lat < 100) begin
            @(posedge clk);
            #1 got_lat++;
        end
        check("bp latency", 32'(got_lat), 32'd3);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("bp hold%0d out_valid", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp hold%0d in_ready", c), 32'(bus.in_ready), 32'd0);
            check($sformatf("bp hold%0d o", c), bus.o, 32'h40700000);
            check($sformatf("bp hold%0d flags", c), 32'(bus.flags), 32'h0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        check("bp in_ready after pop", 32'(bus.in_ready), 32'd1);
        check("bp out_valid after pop", 32'(bus.out_valid), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("bp idle%0d out_valid", c), 32'(bus.out_valid), 32'd0);
            check($sformatf("bp idle%0d in_ready", c), 32'(bus.in_ready), 32'd1);
        end

        // Reset in the middle of a division.
        @(negedge clk);
        bus.a        = 32'h3F800000;
        bus.b        = 32'h40400000;
        bus.opcode   = OP_DIV;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        check("mid-div in_ready", 32'(bus.in_ready), 32'd0);
        check("mid-div out_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async rst in_ready", 32'(bus.in_ready), 32'd1);
        check("async rst out_valid", 32'(bus.out_valid), 32'd0);
        check("async rst o", bus.o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h3FC00000, 32'h40100000, OP_ADD, got_o, got_f, got_lat);
        check("post-rst o", got_o, 32'h40700000);
        check("post-rst flags", 32'(got_f), 32'h0);
        check("post-rst latency", 32'(got_lat), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
